// File: rtl/if_bus_if_pkg.sv
// Shared definitions for the instruction-fetch bus master: FSM encoding, bus
// direction and the ISA no-op word.
package if_bus_if_pkg;

  localparam int unsigned BusIfStateW = 2;

  typedef enum logic [BusIfStateW-1:0] {
    StIdle   = 2'd0,
    StReq    = 2'd1,
    StAccess = 2'd2,
    StStall  = 2'd3
  } bus_if_state_e;

  localparam logic BusRead = 1'b1;

  localparam logic [31:0] IsaNop = 32'h0000_0000;

endpackage

// File: rtl/if_bus_if.sv
// Instruction-fetch bus master: turns the IF pc into a request/grant/strobe/ready
// read on the shared bus and hands the fetched word to the IF register.
module if_bus_if
  import if_bus_if_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [29:0] addr,
  input  logic        as,
  output logic [31:0] insn,
  output logic        busy,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic [29:0] bus_addr,
  output logic        bus_as,
  output logic        bus_rw,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy
);

  bus_if_state_e state;
  logic          drop;
  logic [31:0]   rd_buf;

  assign bus_rw = BusRead;

  // insn and busy are combinational so the data reaches IF in the ready cycle.
  always_comb begin
    insn = IsaNop;
    busy = 1'b0;
    if (!reset) begin
      unique case (state)
        StIdle: begin
          busy = as & ~flush;
        end
        StReq: begin
          busy = 1'b1;
        end
        StAccess: begin
          if (bus_rdy) begin
            if (drop) begin
              busy = as & ~flush;
            end else if (!flush) begin
              insn = bus_rd_data;
            end
          end else begin
            busy = 1'b1;
          end
        end
        StStall: begin
          insn = rd_buf;
        end
        default: begin
          insn = IsaNop;
        end
      endcase
      // Let the pipeline load the flush target even though the bus is still busy.
      if (flush) begin
        busy = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= StIdle;
      bus_req  <= 1'b0;
      bus_as   <= 1'b0;
      bus_addr <= 30'd0;
      drop     <= 1'b0;
      rd_buf   <= IsaNop;
    end else begin
      bus_as <= 1'b0;
      unique case (state)
        StIdle: begin
          if (as && !flush) begin
            bus_req <= 1'b1;
            state   <= StReq;
          end
        end
        StReq: begin
          if (flush) begin
            drop <= 1'b1;
          end
          if (bus_grant) begin
            bus_addr <= addr;
            bus_as   <= 1'b1;
            state    <= StAccess;
          end
        end
        StAccess: begin
          if (bus_rdy) begin
            bus_req <= 1'b0;
            drop    <= 1'b0;
            if (drop || flush) begin
              state <= StIdle;
            end else begin
              rd_buf <= bus_rd_data;
              state  <= stall ? StStall : StIdle;
            end
          end else if (flush) begin
            // The transaction still runs to completion; only its result is dropped.
            drop <= 1'b1;
          end
        end
        StStall: begin
          if (!stall || flush) begin
            state <= StIdle;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_bus_if.sv
// Randomised scoreboard bench for if_bus_if: the stimulus acts as pipeline and bus
// slave, pushing expected bus addresses and delivered words for a monitor to check.
module tb_if_bus_if;

  localparam logic [31:0] Nop = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [29:0] addr;
  logic        as;
  logic [31:0] insn;
  logic        busy;
  logic        bus_req;
  logic        bus_grant;
  logic [29:0] bus_addr;
  logic        bus_as;
  logic        bus_rw;
  logic [31:0] bus_rd_data;
  logic        bus_rdy;

  typedef struct {
    logic [31:0] insn;
    logic        busy;
  } exp_t;

  logic [29:0] exp_addr_q[$];
  exp_t        exp_rd_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          as_count = 0;

  if_bus_if dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .addr       (addr),
    .as         (as),
    .insn       (insn),
    .busy       (busy),
    .bus_req    (bus_req),
    .bus_grant  (bus_grant),
    .bus_addr   (bus_addr),
    .bus_as     (bus_as),
    .bus_rw     (bus_rw),
    .bus_rd_data(bus_rd_data),
    .bus_rdy    (bus_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe consumes one expected address, every ready one expected result.
  always @(negedge clk) begin
    if (bus_as === 1'b1) begin
      as_count++;
      n_cmp++;
      if (exp_addr_q.size() == 0) begin
        n_err++;
        $display("FAIL bus_as_unexpected: got strobe addr %h expected no strobe", bus_addr);
      end else begin
        logic [29:0] ea;
        ea = exp_addr_q.pop_front();
        if (bus_addr !== ea) begin
          n_err++;
          $display("FAIL bus_addr: got %h expected %h at %0t", bus_addr, ea, $time);
        end
      end
    end
    if (bus_rdy === 1'b1) begin
      n_cmp++;
      if (exp_rd_q.size() == 0) begin
        n_err++;
        $display("FAIL rdy_unexpected: got insn %h expected no ready", insn);
      end else begin
        exp_t e;
        e = exp_rd_q.pop_front();
        if (insn !== e.insn || busy !== e.busy) begin
          n_err++;
          $display("FAIL rdy_result: got insn %h busy %b expected insn %h busy %b at %0t",
                   insn, busy, e.insn, e.busy, $time);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One fetch: launch, gwait cycles without grant, grant, rwait cycles without ready,
  // ready. flush_at indexes the cycle after launch carrying a flush (-1: none); hold is
  // the number of cycles stall stays high starting at the ready cycle.
  task automatic do_fetch(input logic [29:0] a, input int gwait, input int rwait,
                          input logic [31:0] data, input int flush_at, input int hold,
                          input logic [29:0] new_pc);
    int          last;
    int          as_before;
    bit          dropped;
    bit          fl;
    logic [29:0] cur;
    last    = gwait + rwait + 1;
    dropped = 1'b0;
    cur     = a;
    as = 1'b1; addr = a; flush = 1'b0; stall = 1'b0; bus_grant = 1'b0; bus_rdy = 1'b0;
    as_before = as_count;
    @(negedge clk);
    check("launch_busy", {31'd0, busy}, 32'd1);
    check("launch_insn", insn, Nop);
    next_cycle();
    for (int w = 0; w <= last; w++) begin
      fl = (w == flush_at);
      if (fl) begin
        dropped = 1'b1;
        cur     = new_pc;
      end
      flush       = fl;
      addr        = cur;
      bus_grant   = (w == gwait);
      bus_rdy     = (w == last);
      bus_rd_data = (w == last) ? data : $urandom;
      stall       = (w == last) && (hold > 0);
      if (w == gwait) exp_addr_q.push_back(cur);
      if (w == last) begin
        exp_t e;
        e.insn = dropped ? Nop : data;
        e.busy = dropped && !fl;
        exp_rd_q.push_back(e);
      end
      @(negedge clk);
      if (w < last) begin
        check("wait_busy", {31'd0, busy}, {31'd0, !fl});
        check("wait_bus_req", {31'd0, bus_req}, 32'd1);
      end
      next_cycle();
    end
    as = 1'b0; flush = 1'b0; bus_grant = 1'b0; bus_rdy = 1'b0;
    if (!dropped && hold > 0) begin
      for (int k = 1; k < hold; k++) begin
        stall = 1'b1;
        @(negedge clk);
        check("stall_insn", insn, data);
        check("stall_busy", {31'd0, busy}, 32'd0);
        next_cycle();
      end
      // Stall released: the buffered word is still presented for this last cycle.
      stall = 1'b0;
      @(negedge clk);
      check("release_insn", insn, data);
      next_cycle();
    end
    stall = 1'b0;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_insn", insn, Nop);
    check("idle_bus_req", {31'd0, bus_req}, 32'd0);
    check("as_pulses", as_count - as_before, 32'd1);
    next_cycle();
  endtask

  task automatic reset_mid(input logic [29:0] a);
    as = 1'b1; addr = a; flush = 1'b0; stall = 1'b0; bus_grant = 1'b0; bus_rdy = 1'b0;
    next_cycle();
    bus_grant = 1'b1;
    exp_addr_q.push_back(a);
    next_cycle();
    bus_grant = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_insn", insn, Nop);
    next_cycle();
    reset = 1'b0;
    as    = 1'b0;
    @(negedge clk);
    check("rst_after_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_after_busy", {31'd0, busy}, 32'd0);
    check("rst_after_insn", insn, Nop);
    next_cycle();
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; addr = 30'd0; as = 1'b0;
    bus_grant = 1'b0; bus_rd_data = 32'd0; bus_rdy = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_bus_as", {31'd0, bus_as}, 32'd0);
    check("rst_bus_addr", {2'd0, bus_addr}, 32'd0);
    check("rst_bus_rw", {31'd0, bus_rw}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_insn", insn, Nop);
    next_cycle();
    reset = 1'b0;

    do_fetch(30'h10, 0, 0, 32'hDEAD_BEEF, -1, 0, 30'h0);
    do_fetch(30'h20, 5, 0, 32'hCAFE_0001, -1, 0, 30'h0);
    do_fetch(30'h30, 0, 1, 32'h1234_5678, -1, 4, 30'h0);
    do_fetch(30'h40, 1, 2, 32'hA5A5_5A5A, 2, 0, 30'h80);
    do_fetch(30'h80, 0, 0, 32'h0BAD_F00D, -1, 0, 30'h0);
    do_fetch(30'h50, 0, 1, 32'h7777_1111, 2, 1, 30'h60);
    reset_mid(30'h90);
    do_fetch(30'hA0, 2, 1, 32'h5555_AAAA, -1, 2, 30'h0);

    for (int i = 0; i < 40; i++) begin
      int g;
      int r;
      int f;
      g = $urandom_range(0, 4);
      r = $urandom_range(0, 4);
      f = ($urandom_range(0, 3) == 0) ? $urandom_range(0, g + r + 1) : -1;
      do_fetch($urandom, g, r, $urandom, f, $urandom_range(0, 3), $urandom);
    end

    next_cycle();
    check("addr_queue_empty", exp_addr_q.size(), 32'd0);
    check("rd_queue_empty", exp_rd_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
